// File: rtl/pkt_fifo_pkg.sv
// rtl/pkt_fifo_pkg.sv - shared constants and helpers for the packet FIFO
package pkt_fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_LEN_LSB  = 2;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Each entry is {sop, data}; the SOP tag sits just above the data word.
  function automatic int sop_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/pkt_fifo_ptr.sv
// rtl/pkt_fifo_ptr.sv - FIFO pointer with wrap bit, cleared on reset or flush
module pkt_fifo_ptr #(
  parameter int PTR_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clock) begin
    if (!resetn || clear) ptr <= '0;
    else if (inc)         ptr <= ptr + PTR_W'(1);
  end

endmodule

// File: rtl/pkt_fifo_gen.sv
// rtl/pkt_fifo_gen.sv - parametrised packet FIFO with SOP/EOP tracking, thresholds and sticky errors
module pkt_fifo_gen
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int LEN_LSB  = DEF_LEN_LSB,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              sop_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              sop_out,
  output logic              rd_valid,
  output logic              eop_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int SOP   = sop_bit(DATA_W);
  localparam int LEN_W = DATA_W - LEN_LSB;
  localparam int REM_W = LEN_W + 1;

  logic [DATA_W:0]  mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [REM_W-1:0] rem;
  logic [DATA_W:0]  rd_entry;
  logic [LEN_W-1:0] len_field;
  logic             wr_acc;
  logic             rd_acc;

  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  assign almost_full  = (level >= AF_LEVEL[ADDR_W:0]);
  assign almost_empty = (level <= AE_LEVEL[ADDR_W:0]);

  assign wr_acc = write_enb && !full;
  assign rd_acc = read_enb && !empty;

  assign rd_entry  = mem[rd_ptr[ADDR_W-1:0]];
  assign len_field = rd_entry[DATA_W-1:LEN_LSB];

  pkt_fifo_ptr #(.PTR_W(ADDR_W + 1)) u_wr_ptr (
    .clock  (clock),
    .resetn (resetn),
    .clear  (soft_reset),
    .inc    (wr_acc),
    .ptr    (wr_ptr)
  );

  pkt_fifo_ptr #(.PTR_W(ADDR_W + 1)) u_rd_ptr (
    .clock  (clock),
    .resetn (resetn),
    .clear  (soft_reset),
    .inc    (rd_acc),
    .ptr    (rd_ptr)
  );

  // Storage is never cleared; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= {sop_in, data_in};
  end

  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      data_out  <= '0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rem       <= '0;
    end else begin
      rd_valid <= rd_acc;
      eop_out  <= 1'b0;
      if (write_enb && full) overflow  <= 1'b1;
      if (read_enb && empty) underflow <= 1'b1;
      if (rd_acc) begin
        data_out <= rd_entry[DATA_W-1:0];
        sop_out  <= rd_entry[SOP];
        // A header always reloads, even mid-packet: truncation is silent.
        if (rd_entry[SOP]) begin
          rem <= {1'b0, len_field} + REM_W'(1);
        end else if (rem != '0) begin
          rem     <= rem - REM_W'(1);
          eop_out <= (rem == REM_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_fifo_gen.sv
// tb/tb_pkt_fifo_gen.sv - scoreboard testbench for pkt_fifo_gen
module tb_pkt_fifo_gen;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       sop_in;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       sop_out;
  logic       rd_valid;
  logic       eop_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  pkt_fifo_gen dut (
    .clock        (clock),
    .resetn       (resetn),
    .soft_reset   (soft_reset),
    .write_enb    (write_enb),
    .sop_in       (sop_in),
    .data_in      (data_in),
    .read_enb     (read_enb),
    .data_out     (data_out),
    .sop_out      (sop_out),
    .rd_valid     (rd_valid),
    .eop_out      (eop_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] mq[$];
  int         mrem;
  logic       exp_valid;
  logic [7:0] exp_data;
  logic       exp_sop;
  logic       exp_eop;

  // One clock of stimulus; the model predicts what the read (if any) shows next cycle.
  task automatic step(input logic we, input logic sp, input logic [7:0] d, input logic re);
    logic       mfull;
    logic       mempty;
    logic [8:0] e;
    @(negedge clock);
    write_enb = we; sop_in = sp; data_in = d; read_enb = re;
    mfull  = (mq.size() == 16);
    mempty = (mq.size() == 0);
    exp_valid = 1'b0;
    exp_eop   = 1'b0;
    if (re && !mempty) begin
      e = mq.pop_front();
      exp_valid = 1'b1;
      exp_data  = e[7:0];
      exp_sop   = e[8];
      if (e[8]) mrem = int'(e[7:2]) + 1;
      else if (mrem != 0) begin
        exp_eop = (mrem == 1);
        mrem--;
      end
    end
    if (we && !mfull) mq.push_back({sp, d});
    @(posedge clock);
    #1;
    write_enb = 1'b0; sop_in = 1'b0; data_in = 8'h00; read_enb = 1'b0;
  endtask

  task automatic pulse_soft_reset();
    @(negedge clock);
    soft_reset = 1'b1;
    @(posedge clock);
    #1;
    soft_reset = 1'b0;
    mq.delete();
    mrem = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    n_checks++;
    if ({level, empty, full, almost_empty, almost_full} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_flags got lvl=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
               level, empty, full, almost_empty, almost_full);
    else n_pass++;
    n_checks++;
    if ({data_out, sop_out, eop_out, rd_valid, overflow, underflow} !== 13'd0)
      $display("FAIL reset_outputs got d=%h s=%b eop=%b v=%b ov=%b un=%b want all 0",
               data_out, sop_out, eop_out, rd_valid, overflow, underflow);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      n_checks++;
      if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 14))
        $display("FAIL fill_level got lvl=%0d af=%b want lvl=%0d af=%b",
                 level, almost_full, i + 1, (i + 1 >= 14));
      else n_pass++;
    end
    n_checks++;
    if (full !== 1'b1 || level !== 5'd16 || almost_full !== 1'b1)
      $display("FAIL fill_full got f=%b lvl=%0d af=%b want 1 16 1", full, level, almost_full);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (rd_valid !== exp_valid || data_out !== exp_data || data_out !== 8'(i) || eop_out !== exp_eop)
        $display("FAIL drain_data got v=%b d=%h eop=%b want v=%b d=%h eop=%b",
                 rd_valid, data_out, eop_out, exp_valid, 8'(i), exp_eop);
      else n_pass++;
    end
    n_checks++;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || level !== 5'd0)
      $display("FAIL drain_empty got e=%b ae=%b lvl=%0d want 1 1 0", empty, almost_empty, level);
    else n_pass++;
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || level !== 5'd16 || underflow !== 1'b0)
      $display("FAIL overflow got ov=%b lvl=%0d un=%b want 1 16 0", overflow, level, underflow);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || data_out !== exp_data || data_out === 8'hAA)
        $display("FAIL ovf_drain got v=%b d=%h want v=1 d=%h", rd_valid, data_out, exp_data);
      else n_pass++;
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b1)
      $display("FAIL underflow got un=%b v=%b ov=%b want 1 0 1", underflow, rd_valid, overflow);
    else n_pass++;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || underflow !== 1'b1)
      $display("FAIL sticky got ov=%b un=%b want 1 1", overflow, underflow);
    else n_pass++;
    pulse_soft_reset();
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL err_clear got ov=%b un=%b want 0 0", overflow, underflow);
    else n_pass++;
  endtask

  task automatic test_packet();
    logic [7:0] words [5];
    words[0] = 8'h0C; words[1] = 8'h11; words[2] = 8'h22; words[3] = 8'h33; words[4] = 8'h44;
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), words[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || data_out !== words[i] || sop_out !== (i == 0) ||
          eop_out !== (i == 4) || eop_out !== exp_eop || sop_out !== exp_sop)
        $display("FAIL packet got v=%b d=%h sop=%b eop=%b want v=1 d=%h sop=%b eop=%b",
                 rd_valid, data_out, sop_out, eop_out, words[i], (i == 0), (i == 4));
      else n_pass++;
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b0 || eop_out !== 1'b0 || data_out !== 8'h44)
      $display("FAIL packet_idle got v=%b eop=%b d=%h want 0 0 44", rd_valid, eop_out, data_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 8'(8'h8A + i), 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || data_out !== exp_data || data_out !== 8'(8'h80 + i) ||
          level !== 5'd10 || full !== 1'b0 || empty !== 1'b0)
        $display("FAIL wrap got v=%b d=%h lvl=%0d f=%b e=%b want v=1 d=%h lvl=10 f=0 e=0",
                 rd_valid, data_out, level, full, empty, 8'(8'h80 + i));
      else n_pass++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (data_out !== exp_data || rd_valid !== 1'b1)
        $display("FAIL wrap_drain got v=%b d=%h want v=1 d=%h", rd_valid, data_out, exp_data);
      else n_pass++;
    end
  endtask

  task automatic test_soft_reset_mid_packet();
    step(1'b1, 1'b1, 8'h14, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h61 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (data_out !== 8'h62 || eop_out !== 1'b0)
      $display("FAIL mid_pkt got d=%h eop=%b want 62 0", data_out, eop_out);
    else n_pass++;
    pulse_soft_reset();
    n_checks++;
    if (level !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00 || rd_valid !== 1'b0 ||
        sop_out !== 1'b0 || eop_out !== 1'b0)
      $display("FAIL soft_reset got lvl=%0d e=%b d=%h v=%b sop=%b eop=%b want 0 1 00 0 0 0",
               level, empty, data_out, rd_valid, sop_out, eop_out);
    else n_pass++;
    step(1'b1, 1'b1, 8'h04, 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b1, 1'b0, 8'h66, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || eop_out !== (i == 2) || eop_out !== exp_eop || data_out !== exp_data)
        $display("FAIL post_flush_pkt got v=%b d=%h eop=%b want v=1 d=%h eop=%b",
                 rd_valid, data_out, eop_out, exp_data, (i == 2));
      else n_pass++;
    end
  endtask

  task automatic test_hard_reset_priority();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (level !== 5'd3 || data_out !== 8'hC1)
      $display("FAIL pre_reset got lvl=%0d d=%h want 3 c1", level, data_out);
    else n_pass++;
    @(negedge clock);
    resetn = 1'b0; soft_reset = 1'b1;
    @(posedge clock);
    #1;
    resetn = 1'b1; soft_reset = 1'b0;
    mq.delete();
    mrem = 0;
    n_checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00 ||
        rd_valid !== 1'b0 || sop_out !== 1'b0 || eop_out !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL hard_reset got lvl=%0d e=%b f=%b d=%h v=%b ov=%b un=%b want 0 1 0 00 0 0 0",
               level, empty, full, data_out, rd_valid, overflow, underflow);
    else n_pass++;
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; sop_in = 1'b0;
    data_in = 8'h00; read_enb = 1'b0; mrem = 0;
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_packet();
    test_back_to_back();
    test_soft_reset_mid_packet();
    test_hard_reset_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
